pc_sequencer: RTL

Control FSM that drives the program-counter register's selection inputs: `pcSrc`, `firstTimeCallAfterD2E`, `firstTimeINTAfterD2E` and `firstTimeRETAfterE2M`. It sequences the multi-cycle CALL, INT and RET redirects, and passes branch and stall requests through when no redirect is in progress. It also latches external interrupt requests and injects them into decode one at a time. It sits between the hazard and branch logic and the PC register, and flushes the front-end on every redirect.

---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// PC-select sequencer: steps through the multi-cycle CALL/INT/RET redirects,
// forwards branch/stall requests while idle, and injects latched interrupts.
module pc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq,
  input  logic       intD2E,
  input  logic       callD2E,
  input  logic       retE2M,
  input  logic       branchTaken,
  input  logic       stall,
  output logic [1:0] pcSrc,
  output logic [1:0] firstTimeCallAfterD2E,
  output logic [1:0] firstTimeINTAfterD2E,
  output logic [1:0] firstTimeRETAfterE2M,
  output logic       flush,
  output logic       intInject,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALL1  = 3'd1,
    INT1   = 3'd2,
    RET_HI = 3'd3,
    RET_LO = 3'd4
  } state_t;

  state_t state, next_state;
  logic   irqPending;
  logic   intInFlight;
  logic   inject_now;

  assign inject_now = irqPending && (state == IDLE) && !intInFlight &&
                      !intD2E && !retE2M && !callD2E;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (intD2E)       next_state = INT1;
        else if (retE2M)  next_state = RET_HI;
        else if (callD2E) next_state = CALL1;
        else              next_state = IDLE;
      end
      CALL1:   next_state = IDLE;
      INT1:    next_state = IDLE;
      RET_HI:  next_state = RET_LO;
      RET_LO:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // An irq sampled on the injection edge keeps the latch set; it is then
  // held off by intInFlight until the injected INT reaches INT1.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqPending  <= 1'b0;
      intInFlight <= 1'b0;
      intInject   <= 1'b0;
    end else begin
      intInject <= inject_now;
      if (irq)             irqPending <= 1'b1;
      else if (inject_now) irqPending <= 1'b0;
      if (inject_now)
        intInFlight <= 1'b1;
      else if (next_state == INT1 && state != INT1)
        intInFlight <= 1'b0;
    end
  end

  always_comb begin
    pcSrc                 = 2'b00;
    firstTimeCallAfterD2E = '0;
    firstTimeINTAfterD2E  = '0;
    firstTimeRETAfterE2M  = '0;
    flush                 = 1'b0;
    busy                  = (state != IDLE);
    unique case (state)
      IDLE: begin
        // Pass-through outputs are suppressed while reset is held.
        if (!reset) begin
          if (branchTaken) pcSrc = 2'b01;
          else if (stall)  pcSrc = 2'b10;
          flush = branchTaken;
        end
      end
      CALL1: begin
        firstTimeCallAfterD2E = 2'b11;
        pcSrc = 2'b10;
        flush = 1'b1;
      end
      INT1: begin
        firstTimeINTAfterD2E = 2'b11;
        pcSrc = 2'b10;
        flush = 1'b1;
      end
      RET_HI: begin
        firstTimeRETAfterE2M = 2'b11;
        pcSrc = 2'b10;
        flush = 1'b1;
      end
      RET_LO: begin
        firstTimeRETAfterE2M = 2'b01;
        pcSrc = 2'b10;
        flush = 1'b1;
      end
      default: begin
        pcSrc = 2'b00;
      end
    endcase
  end

endmodule
